// File: rtl/synth_pkg.sv
// synth_pkg: shared constants and types for the synthesizer voice allocator.
//   NUM_KEYS / NUM_VOICES : size of the key requester set and voice pool.
//   KEY_W / AGE_W / VIDX_W : note index, age counter and voice index widths.
//   voice_t                : one voice table entry {active, note, age}.
//   alloc_state_t          : allocator scan state {IDLE, SCAN}.
package synth_pkg;

  localparam int NUM_KEYS   = 13;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = $clog2(NUM_KEYS);
  localparam int AGE_W      = $clog2(NUM_VOICES) + 1;
  localparam int VIDX_W     = $clog2(NUM_VOICES);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic             active;
    logic [KEY_W-1:0] note;
    logic [AGE_W-1:0] age;
  } voice_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/voice_victim_select.sv
// voice_victim_select: combinational lookup over the voice table for one key.
//   voices     : in,  full voice table.
//   key        : in,  note index currently being scanned.
//   hit        : out, an active voice already holds key; hit_idx is that voice.
//   free       : out, at least one inactive voice; free_idx is the lowest one.
//   victim_idx : out, voice with the largest age, lowest index on a tie.
module voice_victim_select
  import synth_pkg::*;
(
  input  voice_t [NUM_VOICES-1:0] voices,
  input  logic   [KEY_W-1:0]      key,
  output logic                    hit,
  output logic   [VIDX_W-1:0]     hit_idx,
  output logic                    free,
  output logic   [VIDX_W-1:0]     free_idx,
  output logic   [VIDX_W-1:0]     victim_idx
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free       = 1'b0;
    free_idx   = '0;
    victim_idx = '0;
    best_age   = voices[0].age;
    // Walk downward so the lowest matching index is the last one written.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voices[v].active && (voices[v].note == key)) begin
        hit     = 1'b1;
        hit_idx = VIDX_W'(v);
      end
      if (!voices[v].active) begin
        free     = 1'b1;
        free_idx = VIDX_W'(v);
      end
    end
    // Strict greater-than keeps the lowest index on equal ages.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (voices[v].age > best_age) begin
        best_age   = voices[v].age;
        victim_idx = VIDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES oscillator voices among NUM_KEYS keys.
// Scans one key per clock while enabled, allocating, releasing and (optionally)
// stealing voices. Sizes come from synth_pkg.
//   clk          : in,  system clock.
//   nrst         : in,  asynchronous active-low reset.
//   en           : in,  scan enable; low parks the scanner at key 0.
//   keys         : in,  synchronised level key vector, bit k is note k.
//   voice_active : out, gate per voice.
//   voice_note   : out, note per voice, voice v at [v*KEY_W +: KEY_W].
//   voice_retrig : out, one-cycle pulse when a voice takes a new note.
//   busy         : out, high in SCAN; this is the full FSM state.
// Build option: define VOICE_STEAL_EN to let a press with a full pool steal
// the oldest voice; otherwise such a press is ignored and retried next pass.
module voice_allocator
  import synth_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        en,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]       voice_retrig,
  output logic                        busy
);

  alloc_state_t              state;
  logic [KEY_W-1:0]          ptr;
  voice_t [NUM_VOICES-1:0]   voices;
  logic [NUM_VOICES-1:0]     retrig;

  logic                      hit;
  logic [VIDX_W-1:0]         hit_idx;
  logic                      free;
  logic [VIDX_W-1:0]         free_idx;
  logic [VIDX_W-1:0]         victim_idx;

  logic                      pressed;
  logic                      alloc_en;
  logic [VIDX_W-1:0]         alloc_idx;
  logic                      release_en;
  logic [KEY_W-1:0]          ptr_next;

  voice_victim_select u_select (
    .voices     (voices),
    .key        (ptr),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .free       (free),
    .free_idx   (free_idx),
    .victim_idx (victim_idx)
  );

  always_comb begin
    pressed    = keys[ptr];
    release_en = !pressed && hit;
`ifdef VOICE_STEAL_EN
    alloc_en   = pressed && !hit;
    alloc_idx  = free ? free_idx : victim_idx;
`else
    alloc_en   = pressed && !hit && free;
    alloc_idx  = free_idx;
`endif
    ptr_next   = (ptr == KEY_W'(NUM_KEYS - 1)) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      ptr    <= '0;
      voices <= '0;
      retrig <= '0;
    end else begin
      retrig <= '0;
      case (state)
        IDLE: begin
          if (en) state <= SCAN;
        end
        SCAN: begin
          if (!en) begin
            // Voice table is held; only the scan position restarts.
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr_next;
            if (alloc_en) begin
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (VIDX_W'(v) == alloc_idx) begin
                  voices[v] <= '{active: 1'b1, note: ptr, age: '0};
                  retrig[v] <= 1'b1;
                end else if (voices[v].active && (voices[v].age != AGE_MAX)) begin
                  voices[v].age <= voices[v].age + 1'b1;
                end
              end
            end else if (release_en) begin
              // Note and age are kept so the released voice can ring out.
              voices[hit_idx].active <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    voice_active = '0;
    voice_note   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_active[v]                 = voices[v].active;
      voice_note[v*KEY_W +: KEY_W]    = voices[v].note;
    end
    voice_retrig = retrig;
    busy         = (state == SCAN);
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: self-checking bench for voice_allocator. A behavioural
// model of the allocation rules runs alongside the DUT and every cycle's
// outputs are compared; directed scenarios add fixed expected values.
module tb_voice_allocator;
  import synth_pkg::*;

  logic                        clk;
  logic                        nrst;
  logic                        en;
  logic [NUM_KEYS-1:0]         keys;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_note;
  logic [NUM_VOICES-1:0]       voice_retrig;
  logic                        busy;

  int checks;
  int errors;

  voice_allocator dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .keys         (keys),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .voice_retrig (voice_retrig),
    .busy         (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers, one call per clock edge.
  bit m_scan;
  int m_ptr;
  bit m_active [NUM_VOICES];
  int m_note   [NUM_VOICES];
  int m_age    [NUM_VOICES];
  bit m_retrig [NUM_VOICES];

  logic [24:0] dut_vec;
  assign dut_vec = {voice_active, voice_note, voice_retrig, busy};

  task automatic model_reset();
    m_scan = 0;
    m_ptr  = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      m_active[v] = 0; m_note[v] = 0; m_age[v] = 0; m_retrig[v] = 0;
    end
  endtask

  task automatic model_step();
    int holder, tgt, best;
    for (int v = 0; v < NUM_VOICES; v++) m_retrig[v] = 0;
    if (!m_scan) begin
      if (en) m_scan = 1;
    end else if (!en) begin
      m_scan = 0;
      m_ptr  = 0;
    end else begin
      holder = -1;
      for (int v = 0; v < NUM_VOICES; v++)
        if (m_active[v] && m_note[v] == m_ptr && holder < 0) holder = v;
      if (keys[m_ptr] && holder < 0) begin
        tgt = -1;
        for (int v = 0; v < NUM_VOICES; v++)
          if (!m_active[v] && tgt < 0) tgt = v;
`ifdef VOICE_STEAL_EN
        if (tgt < 0) begin
          best = -1;
          for (int v = 0; v < NUM_VOICES; v++)
            if (m_age[v] > best) begin best = m_age[v]; tgt = v; end
        end
`endif
        if (tgt >= 0) begin
          for (int v = 0; v < NUM_VOICES; v++)
            if (v != tgt && m_active[v] && m_age[v] < (1 << AGE_W) - 1) m_age[v]++;
          m_active[tgt] = 1; m_note[tgt] = m_ptr; m_age[tgt] = 0; m_retrig[tgt] = 1;
        end
      end else if (!keys[m_ptr] && holder >= 0) begin
        m_active[holder] = 0;
      end
      m_ptr = (m_ptr + 1) % NUM_KEYS;
    end
  endtask

  function automatic logic [24:0] exp_vec();
    logic [3:0]  a, r;
    logic [15:0] n;
    for (int v = 0; v < NUM_VOICES; v++) begin
      a[v] = m_active[v];
      r[v] = m_retrig[v];
      n[v*4 +: 4] = m_note[v][3:0];
    end
    return {a, n, r, m_scan};
  endfunction

  // Driver tasks
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    nrst = 1'b0;
    model_reset();
    #2;
    nrst = 1'b1;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [3:0] seen;
    nrst = 1'b0; en = 1'b0; keys = '0;
    model_reset();
    #2;
    checks++;
    if (dut_vec !== 25'h0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, 25'h0);
    end
    nrst = 1'b1; en = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_en: got %b expected 1", busy);
    end
    seen = '0;
    repeat (30) begin
      tick();
      seen |= voice_retrig;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL idle_keys: got %h expected %h", dut_vec, exp_vec());
      end
    end
    checks++;
    if ({seen, voice_active} !== 8'h00) begin
      errors++; $display("FAIL no_keys_quiet: got retrig=%b active=%b expected 0", seen, voice_active);
    end
  endtask

  task automatic test_alloc();
    logic [3:0][7:0] pulses;
    hard_reset();
    keys = 13'b0_0000_1001_0001;
    en = 1'b1;
    pulses = '0;
    repeat (14) begin
      tick();
      for (int v = 0; v < NUM_VOICES; v++) pulses[v] += 8'(voice_retrig[v]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL alloc_track: got %h expected %h", dut_vec, exp_vec());
      end
    end
    checks++;
    if ({voice_active, voice_note} !== {4'b0111, 16'h0740}) begin
      errors++; $display("FAIL alloc_table: got %b/%h expected 0111/0740", voice_active, voice_note);
    end
    checks++;
    if (pulses !== 32'h0001_0101) begin
      errors++; $display("FAIL alloc_pulses: got %h expected 00010101", pulses);
    end
  endtask

  task automatic test_release_reuse();
    logic [3:0][7:0] pulses;
    keys[4] = 1'b0;
    repeat (14) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL release_track: got %h expected %h", dut_vec, exp_vec());
      end
    end
    checks++;
    if ({voice_active, voice_note[7:4]} !== {4'b0101, 4'd4}) begin
      errors++; $display("FAIL release_hold_note: got %b/%0d expected 0101/4", voice_active, voice_note[7:4]);
    end
    keys[9] = 1'b1;
    pulses = '0;
    repeat (14) begin
      tick();
      for (int v = 0; v < NUM_VOICES; v++) pulses[v] += 8'(voice_retrig[v]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reuse_track: got %h expected %h", dut_vec, exp_vec());
      end
    end
    checks++;
    if ({voice_active, voice_note[7:4], pulses} !== {4'b0111, 4'd9, 32'h0000_0100}) begin
      errors++; $display("FAIL reuse_voice1: got %b/%0d/%h expected 0111/9/00000100",
                         voice_active, voice_note[7:4], pulses);
    end
  endtask

  task automatic test_steal();
    logic [3:0][7:0] pulses;
    hard_reset();
    keys = '0;
    en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      keys[k] = 1'b1;
      repeat (13) begin
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL fill_track: got %h expected %h", dut_vec, exp_vec());
        end
      end
    end
    checks++;
    if ({voice_active, voice_note} !== {4'b1111, 16'h3210}) begin
      errors++; $display("FAIL pool_full: got %b/%h expected 1111/3210", voice_active, voice_note);
    end
    keys[5] = 1'b1;
    pulses = '0;
    repeat (6) begin
      tick();
      for (int v = 0; v < NUM_VOICES; v++) pulses[v] += 8'(voice_retrig[v]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL steal_track: got %h expected %h", dut_vec, exp_vec());
      end
    end
`ifdef VOICE_STEAL_EN
    checks++;
    if ({voice_active, voice_note, pulses} !== {4'b1111, 16'h3215, 32'h0000_0001}) begin
      errors++; $display("FAIL steal_oldest: got %b/%h/%h expected 1111/3215/00000001",
                         voice_active, voice_note, pulses);
    end
`else
    checks++;
    if ({voice_active, voice_note, pulses} !== {4'b1111, 16'h3210, 32'h0}) begin
      errors++; $display("FAIL no_steal: got %b/%h/%h expected 1111/3210/00000000",
                         voice_active, voice_note, pulses);
    end
`endif
  endtask

  task automatic test_reset_midscan();
    hard_reset();
    keys = 13'b0_0000_1001_0001;
    en = 1'b1;
    repeat (19) tick();
    checks++;
    if (voice_active !== 4'b0111) begin
      errors++; $display("FAIL pre_reset_active: got %b expected 0111", voice_active);
    end
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 25'h0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, 25'h0);
    end
    #1;
    nrst = 1'b1;
    repeat (14) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL realloc_track: got %h expected %h", dut_vec, exp_vec());
      end
    end
    checks++;
    if ({voice_active, voice_note} !== {4'b0111, 16'h0740}) begin
      errors++; $display("FAIL realloc_table: got %b/%h expected 0111/0740", voice_active, voice_note);
    end
  endtask

  task automatic test_en_low();
    logic [24:0] frozen;
    en = 1'b0;
    tick();
    frozen = exp_vec();
    repeat (20) begin
      keys = NUM_KEYS'($urandom_range(0, (1 << NUM_KEYS) - 1));
      tick();
      checks++;
      if (dut_vec !== frozen) begin
        errors++; $display("FAIL parked: got %h expected %h", dut_vec, frozen);
      end
    end
    keys = 13'b0_0010_0010_0010;
    en = 1'b1;
    repeat (14) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL resume_track: got %h expected %h", dut_vec, exp_vec());
      end
    end
    checks++;
    if ({voice_active, voice_note} !== {4'b0111, 16'h0951}) begin
      errors++; $display("FAIL resume_table: got %b/%h expected 0111/0951", voice_active, voice_note);
    end
  endtask

  task automatic test_random();
    hard_reset();
    keys = '0;
    en = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, NUM_KEYS - 1)] ^= 1'b1;
      en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 299) == 0) begin
        nrst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 25'h0) begin
          errors++; $display("FAIL random_reset: got %h expected %h", dut_vec, 25'h0);
        end
        #1;
        nrst = 1'b1;
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_track: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  // Sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    en   = 1'b0;
    keys = '0;
    model_reset();
    #1;
    test_reset();
    test_alloc();
    test_release_reuse();
    test_steal();
    test_reset_midscan();
    test_en_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
